// File: rtl/ps2_key_sequencer_if.sv
// FIFO-side bundle between a PS/2 receiver FIFO and the key sequencer.
// Handshake: ready=1 means data holds a valid head byte; a byte is consumed in
// every cycle where nextdata_n=0, and the FIFO presents the next head afterwards.
interface ps2_key_sequencer_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (output ready, output data, output overflow, input nextdata_n);
  modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_sequencer.sv
// Pops PS/2 scan-code bytes, strips E0/F0 prefixes and reports make/break
// events with typematic-repeat detection and a press counter.
module ps2_key_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_key_sequencer_if.slave   fifo,
  output logic                 evt_valid,
  output logic                 evt_make,
  output logic                 evt_ext,
  output logic                 evt_rpt,
  output logic [7:0]           evt_code,
  output logic                 key_down,
  output logic [7:0]           cur_code,
  output logic                 cur_ext,
  output logic [CNT_W-1:0]     press_count,
  output logic                 err,
  output logic                 ovf_seen,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              ext_f_q, ext_f_d;
  logic              brk_f_q, brk_f_d;
  logic              nextdata_n_q, nextdata_n_d;
  logic              evt_valid_q, evt_valid_d;
  logic              evt_make_q, evt_make_d;
  logic              evt_ext_q, evt_ext_d;
  logic              evt_rpt_q, evt_rpt_d;
  logic [7:0]        evt_code_q, evt_code_d;
  logic              key_down_q, key_down_d;
  logic [7:0]        cur_code_q, cur_code_d;
  logic              cur_ext_q, cur_ext_d;
  logic [CNT_W-1:0]  press_count_q, press_count_d;
  logic              err_q, err_d;
  logic              ovf_seen_q, ovf_seen_d;
  logic              match_cur;

  assign match_cur = (byte_q == cur_code_q) && (ext_f_q == cur_ext_q);

  // The byte is decoded while in POP so its registered result is visible
  // during DECODE, giving the ready -> event latency of two cycles.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    nextdata_n_d  = 1'b1;
    evt_valid_d   = 1'b0;
    evt_make_d    = evt_make_q;
    evt_ext_d     = evt_ext_q;
    evt_rpt_d     = evt_rpt_q;
    evt_code_d    = evt_code_q;
    key_down_d    = key_down_q;
    cur_code_d    = cur_code_q;
    cur_ext_d     = cur_ext_q;
    press_count_d = press_count_q;
    err_d         = 1'b0;
    ovf_seen_d    = ovf_seen_q | fifo.overflow;

    case (state_q)
      IDLE: begin
        if (fifo.ready) begin
          byte_d       = fifo.data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = DECODE;
        case (byte_q)
          8'hE0: ext_f_d = 1'b1;
          8'hF0: brk_f_d = 1'b1;
          8'h00, 8'hFF: begin
            err_d   = 1'b1;
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
          end
          default: begin
            evt_valid_d = 1'b1;
            evt_code_d  = byte_q;
            evt_make_d  = ~brk_f_q;
            evt_ext_d   = ext_f_q;
            evt_rpt_d   = 1'b0;
            ext_f_d     = 1'b0;
            brk_f_d     = 1'b0;
            if (!brk_f_q) begin
              if (key_down_q && match_cur) begin
                evt_rpt_d = 1'b1;
              end else begin
                press_count_d = press_count_q + CNT_W'(1);
                cur_code_d    = byte_q;
                cur_ext_d     = ext_f_q;
                key_down_d    = 1'b1;
              end
            end else if (match_cur) begin
              key_down_d = 1'b0;
            end
          end
        endcase
      end
      DECODE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_q        <= 8'h00;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      nextdata_n_q  <= 1'b1;
      evt_valid_q   <= 1'b0;
      evt_make_q    <= 1'b0;
      evt_ext_q     <= 1'b0;
      evt_rpt_q     <= 1'b0;
      evt_code_q    <= 8'h00;
      key_down_q    <= 1'b0;
      cur_code_q    <= 8'h00;
      cur_ext_q     <= 1'b0;
      press_count_q <= '0;
      err_q         <= 1'b0;
      ovf_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      nextdata_n_q  <= nextdata_n_d;
      evt_valid_q   <= evt_valid_d;
      evt_make_q    <= evt_make_d;
      evt_ext_q     <= evt_ext_d;
      evt_rpt_q     <= evt_rpt_d;
      evt_code_q    <= evt_code_d;
      key_down_q    <= key_down_d;
      cur_code_q    <= cur_code_d;
      cur_ext_q     <= cur_ext_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
      ovf_seen_q    <= ovf_seen_d;
    end
  end

  assign fifo.nextdata_n = nextdata_n_q;
  assign evt_valid       = evt_valid_q;
  assign evt_make        = evt_make_q;
  assign evt_ext         = evt_ext_q;
  assign evt_rpt         = evt_rpt_q;
  assign evt_code        = evt_code_q;
  assign key_down        = key_down_q;
  assign cur_code        = cur_code_q;
  assign cur_ext         = cur_ext_q;
  assign press_count     = press_count_q;
  assign err             = err_q;
  assign ovf_seen        = ovf_seen_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of the press counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-004 Port: ready  input  1  PS/2 receiver FIFO holds at least one scan-code byte.
REQ-005 Port: data  input  8  scan-code byte at the FIFO head; valid while ready=1.
REQ-006 Port: overflow  input  1  PS/2 receiver FIFO overflow flag.
REQ-007 Port: nextdata_n  output  1  active-low FIFO pop; low for exactly one cycle per byte consumed.
REQ-008 Port: evt_valid  output  1  one-cycle pulse qualifying evt_make, evt_ext, evt_rpt and evt_code.
REQ-009 Port: evt_make  output  1  1 = key press (make), 0 = key release (break).
REQ-010 Port: evt_ext  output  1  event was prefixed by 0xE0.
REQ-011 Port: evt_rpt  output  1  make event is a typematic repeat of the held key.
REQ-012 Port: evt_code  output  8  scan code of the event, with prefixes stripped.
REQ-013 Port: key_down  output  1  the last newly pressed key is still held.
REQ-014 Port: cur_code  output  8  code of the last newly pressed key.
REQ-015 Port: cur_ext  output  1  extended flag of the last newly pressed key.
REQ-016 Port: press_count  output  CNT_W  count of non-repeat make events.
REQ-017 Port: err  output  1  one-cycle pulse on a protocol error byte.
REQ-018 Port: ovf_seen  output  1  sticky record of overflow; cleared only by reset.

Function
REQ-019 The FSM SHALL have three states: IDLE, POP and DECODE.
REQ-020 IDLE with ready=1: latch data into byte_r, drive nextdata_n low for the next cycle, go to POP. IDLE with ready=0: stay in IDLE.
REQ-021 POP: return nextdata_n high at the next edge and go to DECODE; ready and data are ignored during POP and DECODE.
REQ-022 All outputs SHALL be registered. Latency: ready=1 sampled in IDLE at cycle N; nextdata_n=0 in cycle N+1; evt_valid or err in cycle N+2; the FSM is back in IDLE in cycle N+3.
REQ-023 Maximum throughput SHALL be one byte per 3 cycles; back-to-back bytes are never dropped while ready stays high.
REQ-024 DECODE, byte_r=0xE0: set ext_f, no event, go to IDLE.
REQ-025 DECODE, byte_r=0xF0: set brk_f, no event, go to IDLE; a prefix sequence F0 then E0 SHALL also set ext_f.
REQ-026 DECODE, byte_r=0x00 or 0xFF: pulse err, clear ext_f and brk_f, no event, go to IDLE.
REQ-027 DECODE, any other byte: pulse evt_valid with evt_code=byte_r, evt_make=~brk_f and evt_ext=ext_f; clear both flags; go to IDLE.
REQ-028 Make event with key_down=1, code=cur_code and ext=cur_ext: evt_rpt=1; press_count and cur_* SHALL be unchanged.
REQ-029 Any other make event: evt_rpt=0, press_count+1 (modulo 2^CNT_W, wrapping silently), cur_code/cur_ext updated, key_down=1.
REQ-030 Break event matching cur_code/cur_ext: key_down=0. A non-matching break SHALL be reported but SHALL leave key_down unchanged.
REQ-031 evt_rpt SHALL be 0 on break events. evt_* fields SHALL hold their last values when evt_valid=0.
REQ-032 Any cycle with overflow=1 SHALL set ovf_seen; setting it SHALL not affect decoding.

Reset
REQ-033 While reset=1: state=IDLE, nextdata_n=1, all flags and registers 0, and evt_valid, evt_make, evt_ext, evt_rpt, evt_code, key_down, cur_code, cur_ext, press_count, err and ovf_seen all 0.
REQ-034 Reset mid-sequence SHALL discard pending prefixes and any byte latched but not yet decoded; a pop already issued is not retried.
REQ-035 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-036 Reset, then FIFO byte 0x1C -> one nextdata_n low pulse; 2 cycles later evt_valid with make=1, ext=0, code=1C; press_count=1, key_down=1, cur_code=1C.
REQ-037 After REQ-036, feed F0,1C -> one event with make=0, code=1C; key_down=0; press_count=1; exactly 2 pops.
REQ-038 Feed 1C,1C,1C -> 3 events with evt_rpt=0,1,1; press_count=1.
REQ-039 Feed E0,75 then E0,F0,75 -> make ext=1 code=75, then break ext=1 code=75; key_down=0; cur_ext=1.
REQ-040 Start with press_count=255 and CNT_W=8, then press a new key 0x15 -> press_count=0; feed byte 0x00 -> err pulse and no event.
REQ-041 Feed F0, assert reset for 1 cycle, then feed 1C -> make event (evt_make=1); overflow pulse -> ovf_seen=1 until the next reset.
